// File: rtl/rs_pkg.sv
// rs_pkg: shared definitions for the multi-CDB ALU reservation station.
//   OPCODE_W / FUNCT3_W : uop field widths
//   tag helpers         : pending-bit position and tag construction
//   cdb_slice           : extracts channel k of a packed broadcast bus
package rs_pkg;

   localparam int OPCODE_W    = 7;
   localparam int FUNCT3_W    = 3;

   // Helpers work on generously sized vectors; callers cast down to their widths.
   localparam int TAG_MAX     = 17;
   localparam int FIELD_MAX   = 64;
   localparam int CDB_BUS_MAX = 1024;

   // A tag is {pending, rob_pos}; pending sits just above the ROB index.
   function automatic int unsigned tag_pend_bit(input int unsigned rob_w);
      return rob_w;
   endfunction

   function automatic logic [TAG_MAX-1:0] make_tag(input logic pend,
                                                   input logic [TAG_MAX-2:0] pos,
                                                   input int unsigned rob_w);
      logic [TAG_MAX-1:0] t;
      t = {1'b0, pos};
      t[tag_pend_bit(rob_w)] = pend;
      return t;
   endfunction

   function automatic logic [FIELD_MAX-1:0] cdb_slice(input logic [CDB_BUS_MAX-1:0] bus,
                                                      input int unsigned k,
                                                      input int unsigned w);
      logic [CDB_BUS_MAX-1:0] sh;
      sh = bus >> (k * w);
      return sh[FIELD_MAX-1:0] & ({FIELD_MAX{1'b1}} >> (FIELD_MAX - w));
   endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select: combinational dispatch picker.
//   ready : per-entry eligibility
//   ages  : per-entry age (ignored ordering-wise when USE_AGE=0, tie to 0)
//   idx   : chosen entry, found : any entry eligible
// USE_AGE=1 : maximum age wins, ties to the lowest index.
// USE_AGE=0 : highest ready index wins.
module rs_select #(
   parameter int DEPTH   = 16,
   parameter int AGE_W   = 4,
   parameter bit USE_AGE = 1'b0
) (
   input  logic [DEPTH-1:0]            ready,
   input  logic [DEPTH-1:0][AGE_W-1:0] ages,
   output logic [$clog2(DEPTH)-1:0]    idx,
   output logic                        found
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [AGE_W-1:0] best;

   // Ascending scan: a strictly older entry replaces the pick; without ages
   // every later ready entry replaces it, leaving the highest index.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      best  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!found || (ages[i] > best) || (!USE_AGE && ages[i] == best))) begin
            found = 1'b1;
            idx   = IDX_W'(i);
            best  = ages[i];
         end
      end
   end

endmodule

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: ALU reservation station snooping NUM_CDB broadcast channels.
// Holds issued uops until both operands resolve, dispatches one per cycle
// through a valid/ready output register.
//   clk, rst_n (async low), rdy (global enable), rollback (sync flush)
//   issue_*   : allocation port, rs_nxt_full tells the issuer to stall
//   cdb_*     : packed broadcast channels, channel 0 highest priority
//   alu_*     : dispatch payload, alu_en/alu_ready handshake
// Build option: define RS_AGE_SELECT_EN for oldest-first dispatch; otherwise
// the highest-index ready entry is dispatched.
module rs_multi_cdb
   import rs_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int NUM_CDB   = 2,
   parameter int ROB_POS_W = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rdy,
   input  logic                          rollback,
   output logic                          rs_nxt_full,
   input  logic                          issue,
   input  logic [ROB_POS_W-1:0]          issue_rob_pos,
   input  logic [OPCODE_W-1:0]           issue_opcode,
   input  logic [FUNCT3_W-1:0]           issue_funct3,
   input  logic                          issue_funct7,
   input  logic [DATA_W-1:0]             issue_rs1_val,
   input  logic [DATA_W-1:0]             issue_rs2_val,
   input  logic [ROB_POS_W:0]            issue_rs1_tag,
   input  logic [ROB_POS_W:0]            issue_rs2_tag,
   input  logic [DATA_W-1:0]             issue_imm,
   input  logic [ADDR_W-1:0]             issue_pc,
   input  logic [NUM_CDB-1:0]            cdb_valid,
   input  logic [NUM_CDB*ROB_POS_W-1:0]  cdb_rob_pos,
   input  logic [NUM_CDB*DATA_W-1:0]     cdb_val,
   output logic                          alu_en,
   input  logic                          alu_ready,
   output logic [OPCODE_W-1:0]           alu_opcode,
   output logic [FUNCT3_W-1:0]           alu_funct3,
   output logic                          alu_funct7,
   output logic [DATA_W-1:0]             alu_val1,
   output logic [DATA_W-1:0]             alu_val2,
   output logic [DATA_W-1:0]             alu_imm,
   output logic [ADDR_W-1:0]             alu_pc,
   output logic [ROB_POS_W-1:0]          alu_rob_pos
);

   localparam int TAG_W = ROB_POS_W + 1;
   localparam int PEND  = ROB_POS_W;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int AGE_W = IDX_W;

   typedef struct packed {
      logic [OPCODE_W-1:0]  opcode;
      logic [FUNCT3_W-1:0]  funct3;
      logic                 funct7;
      logic [DATA_W-1:0]    val1;
      logic [DATA_W-1:0]    val2;
      logic [TAG_W-1:0]     tag1;
      logic [TAG_W-1:0]     tag2;
      logic [DATA_W-1:0]    imm;
      logic [ADDR_W-1:0]    pc;
      logic [ROB_POS_W-1:0] rob_pos;
   } ent_t;

   ent_t                              ent [DEPTH];
   logic [DEPTH-1:0]                  busy, busy_nxt, ready;
   logic [NUM_CDB-1:0][ROB_POS_W-1:0] cdb_pos;
   logic [NUM_CDB-1:0][DATA_W-1:0]    cdb_data;
   logic [DEPTH-1:0][AGE_W-1:0]       ages;
   logic [IDX_W-1:0]                  free_idx, sel_idx;
   logic [CNT_W-1:0]                  free_cnt;
   logic                              free_found, sel_found, issue_ok, slot_free, do_disp;
   logic [DATA_W:0]                   snp1, snp2;
   logic [TAG_W-1:0]                  iss_t1, iss_t2;

   // ---- broadcast bus unpack
   for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
      assign cdb_pos[k]  = ROB_POS_W'(cdb_slice(CDB_BUS_MAX'(cdb_rob_pos), k, ROB_POS_W));
      assign cdb_data[k] = DATA_W'(cdb_slice(CDB_BUS_MAX'(cdb_val), k, DATA_W));
   end

   // Returns {hit, value}; scanning downward lets the lowest channel win.
   function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag,
                                             input logic [NUM_CDB-1:0] vld,
                                             input logic [NUM_CDB-1:0][ROB_POS_W-1:0] pos,
                                             input logic [NUM_CDB-1:0][DATA_W-1:0] dat);
      logic [DATA_W:0] r;
      r = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--)
         if (tag[PEND] && vld[k] && pos[k] == tag[ROB_POS_W-1:0])
            r = {1'b1, dat[k]};
      return r;
   endfunction

   // ---- free slot search and occupancy
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      free_cnt   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
            free_cnt   = free_cnt + CNT_W'(1);
         end
      end
   end

   // An issue into a full station is simply dropped.
   assign rs_nxt_full = (free_cnt <= CNT_W'(issue));
   assign issue_ok    = rdy && !rollback && issue && free_found;

   // Issue-time bypass: a pending operand broadcast this cycle is stored resolved.
   assign snp1   = snoop(issue_rs1_tag, cdb_valid, cdb_pos, cdb_data);
   assign snp2   = snoop(issue_rs2_tag, cdb_valid, cdb_pos, cdb_data);
   assign iss_t1 = TAG_W'(make_tag(issue_rs1_tag[PEND] & ~snp1[DATA_W],
                                   (TAG_MAX-1)'(issue_rs1_tag[ROB_POS_W-1:0]), ROB_POS_W));
   assign iss_t2 = TAG_W'(make_tag(issue_rs2_tag[PEND] & ~snp2[DATA_W],
                                   (TAG_MAX-1)'(issue_rs2_tag[ROB_POS_W-1:0]), ROB_POS_W));

   // ---- readiness from registered state only, so wakeup costs one cycle
   for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
      assign ready[i] = busy[i] && !ent[i].tag1[PEND] && !ent[i].tag2[PEND];
   end

`ifdef RS_AGE_SELECT_EN
   localparam bit USE_AGE = 1'b1;
   logic [DEPTH-1:0][AGE_W-1:0] age;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age <= '0;
      end else if (issue_ok) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (free_idx == IDX_W'(i))
               age[i] <= '0;
            else if (busy[i] && age[i] != '1)
               age[i] <= age[i] + AGE_W'(1);
         end
      end
   end

   assign ages = age;
`else
   localparam bit USE_AGE = 1'b0;
   assign ages = '0;
`endif

   rs_select #(.DEPTH(DEPTH), .AGE_W(AGE_W), .USE_AGE(USE_AGE)) u_sel (
      .ready (ready),
      .ages  (ages),
      .idx   (sel_idx),
      .found (sel_found)
   );

   assign slot_free = !alu_en || alu_ready;
   assign do_disp   = slot_free && sel_found;

   // The issue slot comes from pre-edge busy, so it never reuses the entry
   // leaving through dispatch in the same cycle.
   always_comb begin
      busy_nxt = busy;
      if (do_disp)  busy_nxt[sel_idx]  = 1'b0;
      if (issue_ok) busy_nxt[free_idx] = 1'b1;
   end

   // ---- entry payload storage (no reset: busy qualifies every field)
   always_ff @(posedge clk) begin
      if (rdy && !rollback) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (issue_ok && free_idx == IDX_W'(i)) begin
               ent[i].opcode  <= issue_opcode;
               ent[i].funct3  <= issue_funct3;
               ent[i].funct7  <= issue_funct7;
               ent[i].val1    <= snp1[DATA_W] ? snp1[DATA_W-1:0] : issue_rs1_val;
               ent[i].val2    <= snp2[DATA_W] ? snp2[DATA_W-1:0] : issue_rs2_val;
               ent[i].tag1    <= iss_t1;
               ent[i].tag2    <= iss_t2;
               ent[i].imm     <= issue_imm;
               ent[i].pc      <= issue_pc;
               ent[i].rob_pos <= issue_rob_pos;
            end else if (busy[i]) begin
               logic [DATA_W:0] s1, s2;
               s1 = snoop(ent[i].tag1, cdb_valid, cdb_pos, cdb_data);
               s2 = snoop(ent[i].tag2, cdb_valid, cdb_pos, cdb_data);
               if (s1[DATA_W]) begin
                  ent[i].val1       <= s1[DATA_W-1:0];
                  ent[i].tag1[PEND] <= 1'b0;
               end
               if (s2[DATA_W]) begin
                  ent[i].val2       <= s2[DATA_W-1:0];
                  ent[i].tag2[PEND] <= 1'b0;
               end
            end
         end
      end
   end

   // ---- occupancy and dispatch register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= '0;
         alu_en      <= 1'b0;
         alu_opcode  <= '0;
         alu_funct3  <= '0;
         alu_funct7  <= 1'b0;
         alu_val1    <= '0;
         alu_val2    <= '0;
         alu_imm     <= '0;
         alu_pc      <= '0;
         alu_rob_pos <= '0;
      end else if (rdy) begin
         if (rollback) begin
            busy   <= '0;
            alu_en <= 1'b0;
         end else begin
            busy <= busy_nxt;
            if (slot_free) begin
               alu_en <= sel_found;
               if (sel_found) begin
                  alu_opcode  <= ent[sel_idx].opcode;
                  alu_funct3  <= ent[sel_idx].funct3;
                  alu_funct7  <= ent[sel_idx].funct7;
                  alu_val1    <= ent[sel_idx].val1;
                  alu_val2    <= ent[sel_idx].val2;
                  alu_imm     <= ent[sel_idx].imm;
                  alu_pc      <= ent[sel_idx].pc;
                  alu_rob_pos <= ent[sel_idx].rob_pos;
               end
            end
         end
      end
   end

endmodule
